// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter
// Shares one I2C master pin path between two transaction engines. Ownership is
// granted round-robin once the bus has been quiet for IDLE_CYCLES cycles, held
// until the owner drops its request, and forcibly revoked after TIMEOUT cycles.
// A requester that was revoked must drop its request before it is eligible again.
// sel steers the SDA/SCL muxes: 1 routes requester 0, 0 routes requester 1.

module i2c_bus_arbiter #(
    parameter int IDLE_CYCLES = 8,
    parameter int TIMEOUT     = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    input  logic scl_in,
    input  logic sda_in,
    output logic gnt0,
    output logic gnt1,
    output logic sel,
    output logic busy,
    output logic timeout_err
);

    localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
    localparam int HOLD_W = $clog2(TIMEOUT);

    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(IDLE_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
    localparam logic [IDLE_W-1:0] IDLE_ZERO = IDLE_W'(0);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(TIMEOUT - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(0);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    // state registers
    logic [1:0]        state_r;
    logic [IDLE_W-1:0] idle_cnt_r;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic              last_r;      // index of the most recent owner
    logic              lock0_r;
    logic              lock1_r;
    logic              gnt0_r;
    logic              gnt1_r;
    logic              sel_r;
    logic              busy_r;
    logic              err_r;

    // next-state values
    logic [1:0]        state_next_s;
    logic [IDLE_W-1:0] idle_next_s;
    logic [HOLD_W-1:0] hold_next_s;
    logic              last_next_s;
    logic              lock0_next_s;
    logic              lock1_next_s;
    logic              gnt0_next_s;
    logic              gnt1_next_s;
    logic              sel_next_s;
    logic              busy_next_s;
    logic              err_next_s;

    logic              bus_free_s;
    logic              elig0_s;
    logic              elig1_s;

    assign bus_free_s = (idle_cnt_r == IDLE_MAX);
    assign elig0_s    = req0 & ~lock0_r;
    assign elig1_s    = req1 & ~lock1_r;

    // Arbitration, guard-time and hold-timeout next-state logic
    always_comb begin
        state_next_s = state_r;
        hold_next_s  = hold_cnt_r;
        last_next_s  = last_r;
        lock0_next_s = lock0_r & req0;   // a dropped request clears its lock
        lock1_next_s = lock1_r & req1;
        gnt0_next_s  = gnt0_r;
        gnt1_next_s  = gnt1_r;
        sel_next_s   = sel_r;
        err_next_s   = 1'b0;

        // Quiet-bus counter: saturates once the guard time is met
        if (scl_in & sda_in) begin
            if (bus_free_s) begin
                idle_next_s = idle_cnt_r;
            end else begin
                idle_next_s = idle_cnt_r + IDLE_ONE;
            end
        end else begin
            idle_next_s = IDLE_ZERO;
        end

        case (state_r)
            ST_IDLE: begin
                // When both are eligible, favour the one that did not own last
                if (bus_free_s && elig0_s && (!elig1_s || last_r)) begin
                    state_next_s = ST_OWN0;
                    gnt0_next_s  = 1'b1;
                    sel_next_s   = 1'b1;
                    hold_next_s  = HOLD_ZERO;
                end else if (bus_free_s && elig1_s) begin
                    state_next_s = ST_OWN1;
                    gnt1_next_s  = 1'b1;
                    sel_next_s   = 1'b0;
                    hold_next_s  = HOLD_ZERO;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_OWN0: begin
                if (!req0) begin
                    state_next_s = ST_IDLE;
                    gnt0_next_s  = 1'b0;
                    last_next_s  = 1'b0;
                    idle_next_s  = IDLE_ZERO;
                end else if (hold_cnt_r == HOLD_LAST) begin
                    state_next_s = ST_IDLE;
                    gnt0_next_s  = 1'b0;
                    last_next_s  = 1'b0;
                    lock0_next_s = 1'b1;
                    err_next_s   = 1'b1;
                    idle_next_s  = IDLE_ZERO;
                end else begin
                    hold_next_s  = hold_cnt_r + HOLD_ONE;
                end
            end
            ST_OWN1: begin
                if (!req1) begin
                    state_next_s = ST_IDLE;
                    gnt1_next_s  = 1'b0;
                    last_next_s  = 1'b1;
                    idle_next_s  = IDLE_ZERO;
                end else if (hold_cnt_r == HOLD_LAST) begin
                    state_next_s = ST_IDLE;
                    gnt1_next_s  = 1'b0;
                    last_next_s  = 1'b1;
                    lock1_next_s = 1'b1;
                    err_next_s   = 1'b1;
                    idle_next_s  = IDLE_ZERO;
                end else begin
                    hold_next_s  = hold_cnt_r + HOLD_ONE;
                end
            end
            default: begin
                // Unreachable encoding: drop any grant and return to idle
                state_next_s = ST_IDLE;
                gnt0_next_s  = 1'b0;
                gnt1_next_s  = 1'b0;
            end
        endcase

        busy_next_s = gnt0_next_s | gnt1_next_s;
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            idle_cnt_r <= IDLE_ZERO;
            hold_cnt_r <= HOLD_ZERO;
            last_r     <= 1'b1;
            lock0_r    <= 1'b0;
            lock1_r    <= 1'b0;
            gnt0_r     <= 1'b0;
            gnt1_r     <= 1'b0;
            sel_r      <= 1'b1;
            busy_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            idle_cnt_r <= idle_next_s;
            hold_cnt_r <= hold_next_s;
            last_r     <= last_next_s;
            lock0_r    <= lock0_next_s;
            lock1_r    <= lock1_next_s;
            gnt0_r     <= gnt0_next_s;
            gnt1_r     <= gnt1_next_s;
            sel_r      <= sel_next_s;
            busy_r     <= busy_next_s;
            err_r      <= err_next_s;
        end
    end

    assign gnt0        = gnt0_r;
    assign gnt1        = gnt1_r;
    assign sel         = sel_r;
    assign busy        = busy_r;
    assign timeout_err = err_r;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Testbench for i2c_bus_arbiter (IDLE_CYCLES=8, TIMEOUT=16): a vector table for
// reset/first grant/round-robin/guard restart, hand sequences for timeout and
// asynchronous reset, and a randomized run against a rules-level model.

module tb_i2c_bus_arbiter;

    localparam int IDLE = 8;
    localparam int TMO  = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req0 = 1'b0;
    logic req1 = 1'b0;
    logic scl_in = 1'b1;
    logic sda_in = 1'b1;
    logic gnt0, gnt1, sel, busy, timeout_err;

    int total  = 0;
    int passed = 0;

    i2c_bus_arbiter #(.IDLE_CYCLES(IDLE), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
        .scl_in(scl_in), .sda_in(sda_in),
        .gnt0(gnt0), .gnt1(gnt1), .sel(sel), .busy(busy),
        .timeout_err(timeout_err)
    );

    // Free-running 10-unit clock
    always #5 clk = ~clk;

    // Hard stop if the run ever stalls
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit r0, input bit r1);
        rst_n  = 1'b0;
        req0   = r0;
        req1   = r1;
        scl_in = 1'b1;
        sda_in = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Counts edges until the chosen grant rises; -1 if the bound expires
    task automatic wait_grant(input int which, input int max_edges, output int edges);
        bit seen;
        seen  = 1'b0;
        edges = -1;
        for (int i = 1; i <= max_edges; i++) begin
            if (!seen) begin
                tick();
                if ((which == 0) ? gnt0 : gnt1) begin
                    seen  = 1'b1;
                    edges = i;
                end
            end
        end
    endtask

    // ---------------- reference model (rules level) ----------------
    int m_owner;     // -1 none, else owning requester
    int m_quiet;     // consecutive quiet cycles since last activity/release
    int m_age;       // cycles the current grant has been visible
    int m_last;
    bit m_lock[2];
    bit m_sel;
    bit m_err;

    function automatic void model_reset();
        m_owner = -1; m_quiet = 0; m_age = 0; m_last = 1;
        m_lock[0] = 1'b0; m_lock[1] = 1'b0; m_sel = 1'b1; m_err = 1'b0;
    endfunction

    function automatic void model_step(bit r0, bit r1, bit line_high);
        bit rq[2];
        bit el[2];
        int nq;
        int pick;
        rq[0] = r0; rq[1] = r1;
        el[0] = r0 && !m_lock[0];
        el[1] = r1 && !m_lock[1];
        m_err = 1'b0;
        nq = line_high ? m_quiet + 1 : 0;
        if (m_owner < 0) begin
            pick = -1;
            if (m_quiet >= IDLE) begin
                if (el[0] && el[1]) pick = 1 - m_last;
                else if (el[0])     pick = 0;
                else if (el[1])     pick = 1;
            end
            if (pick >= 0) begin
                m_owner = pick; m_age = 1; m_sel = (pick == 0);
            end
        end else if (!rq[m_owner]) begin
            m_last = m_owner; m_owner = -1; nq = 0;
        end else if (m_age == TMO) begin
            m_last = m_owner; m_lock[m_owner] = 1'b1; m_err = 1'b1;
            m_owner = -1; nq = 0;
        end else begin
            m_age++;
        end
        for (int i = 0; i < 2; i++) if (!rq[i]) m_lock[i] = 1'b0;
        m_quiet = nq;
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        int n;
        bit r0, r1, scl, sda;
        bit g0, g1, s, e;
    } vec_t;

    vec_t vecs[$];

    // Main test sequence
    initial begin
        int e;
        int cnt;
        int hits;
        bit done;
        bit r0, r1, sc, sd;

        //        n   r0 r1 scl sda  g0 g1 sel err
        vecs.push_back(vec_t'{8, 0, 1, 1, 1, 0, 0, 1, 0}); // guard after reset
        vecs.push_back(vec_t'{1, 0, 1, 1, 1, 0, 1, 0, 0}); // first grant at edge 9
        vecs.push_back(vec_t'{3, 0, 1, 1, 1, 0, 1, 0, 0});
        vecs.push_back(vec_t'{1, 0, 0, 1, 1, 0, 0, 0, 0}); // release, sel holds
        vecs.push_back(vec_t'{8, 1, 1, 1, 1, 0, 0, 0, 0});
        vecs.push_back(vec_t'{1, 1, 1, 1, 1, 1, 0, 1, 0}); // round-robin to 0
        vecs.push_back(vec_t'{2, 1, 1, 1, 1, 1, 0, 1, 0});
        vecs.push_back(vec_t'{1, 0, 1, 1, 1, 0, 0, 1, 0}); // req0 dropped 1 cycle
        vecs.push_back(vec_t'{8, 1, 1, 1, 1, 0, 0, 1, 0});
        vecs.push_back(vec_t'{1, 1, 1, 1, 1, 0, 1, 0, 0}); // 1 wins, req0 back high
        vecs.push_back(vec_t'{1, 1, 0, 1, 1, 0, 0, 0, 0});
        vecs.push_back(vec_t'{8, 1, 0, 1, 1, 0, 0, 0, 0});
        vecs.push_back(vec_t'{1, 1, 0, 1, 1, 1, 0, 1, 0}); // 0 granted next
        vecs.push_back(vec_t'{1, 0, 0, 1, 1, 0, 0, 1, 0});
        vecs.push_back(vec_t'{4, 0, 1, 1, 1, 0, 0, 1, 0}); // guard cycles 1-4
        vecs.push_back(vec_t'{1, 0, 1, 1, 0, 0, 0, 1, 0}); // SDA low at cycle 5
        vecs.push_back(vec_t'{8, 0, 1, 1, 1, 0, 0, 1, 0}); // full guard again
        vecs.push_back(vec_t'{1, 0, 1, 1, 1, 0, 1, 0, 0});
        vecs.push_back(vec_t'{1, 0, 0, 1, 1, 0, 0, 0, 0});

        // Test 1: reset values while held in reset
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b1; scl_in = 1'b1; sda_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt0", gnt0, 0);
        check("rst_gnt1", gnt1, 0);
        check("rst_sel", sel, 1);
        check("rst_busy", busy, 0);
        check("rst_err", timeout_err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Tests 1-3: table, every row checked on every cycle
        foreach (vecs[k]) begin
            req0 = vecs[k].r0; req1 = vecs[k].r1;
            scl_in = vecs[k].scl; sda_in = vecs[k].sda;
            for (int c = 0; c < vecs[k].n; c++) begin
                tick();
                check($sformatf("vec%0d_gnt0", k), gnt0, vecs[k].g0);
                check($sformatf("vec%0d_gnt1", k), gnt1, vecs[k].g1);
                check($sformatf("vec%0d_sel", k), sel, vecs[k].s);
                check($sformatf("vec%0d_busy", k), busy, vecs[k].g0 | vecs[k].g1);
                check($sformatf("vec%0d_err", k), timeout_err, vecs[k].e);
            end
        end

        // Test 4a: hung owner is revoked after exactly TMO cycles
        do_reset(1'b1, 1'b1);
        wait_grant(0, 30, e);
        check("t4_grant_lat", e, 9);
        cnt = 1; done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!done) begin
                tick();
                if (gnt0) cnt++;
                else done = 1'b1;
            end
        end
        check("t4_hold_cycles", cnt, TMO);
        check("t4_err_pulse", timeout_err, 1);
        check("t4_gnt1_not_yet", gnt1, 0);
        tick();
        check("t4_err_one_cycle", timeout_err, 0);
        wait_grant(1, 30, e);
        check("t4_req1_after_guard", e, IDLE);
        check("t4_sel_req1", sel, 0);
        req1 = 1'b0;
        tick();
        hits = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (gnt0) hits++;
        end
        check("t4_locked_no_regrant", hits, 0);
        req0 = 1'b0;
        tick();
        req0 = 1'b1;
        wait_grant(0, 30, e);
        check("t4_regrant_after_drop", e, 1);

        // Test 4b: request dropped on the last allowed cycle is a normal release
        do_reset(1'b1, 1'b0);
        wait_grant(0, 30, e);
        check("t4b_grant_lat", e, 9);
        repeat (TMO - 1) tick();
        check("t4b_still_owned", gnt0, 1);
        req0 = 1'b0;
        tick();
        check("t4b_released", gnt0, 0);
        check("t4b_no_err", timeout_err, 0);
        tick();
        check("t4b_no_err_later", timeout_err, 0);

        // Test 5: asynchronous reset between edges while requester 1 owns
        do_reset(1'b0, 1'b1);
        wait_grant(1, 30, e);
        check("t5_grant1_lat", e, 9);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_gnt1", gnt1, 0);
        check("t5_async_sel", sel, 1);
        check("t5_async_busy", busy, 0);
        do_reset(1'b1, 1'b1);
        wait_grant(0, 30, e);
        check("t5_last_reset_gnt0_first", e, 9);
        check("t5_gnt1_low", gnt1, 0);

        // Test 6: random stimulus against the model
        do_reset(1'b0, 1'b0);
        model_reset();
        r0 = 1'b0; r1 = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 19) == 0) r0 = ~r0;
            if ($urandom_range(0, 19) == 0) r1 = ~r1;
            sc = ($urandom_range(0, 15) != 0);
            sd = ($urandom_range(0, 15) != 0);
            req0 = r0; req1 = r1; scl_in = sc; sda_in = sd;
            model_step(r0, r1, sc & sd);
            tick();
            check("t6_gnt0", gnt0, (m_owner == 0));
            check("t6_gnt1", gnt1, (m_owner == 1));
            check("t6_sel", sel, m_sel);
            check("t6_busy", busy, (m_owner >= 0));
            check("t6_err", timeout_err, m_err);
            check("t6_mutex", gnt0 & gnt1, 0);
            if (gnt0) check("t6_sel_gnt0", sel, 1);
            if (gnt1) check("t6_sel_gnt1", sel, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/i2c_bus_arbiter.md
# i2c_bus_arbiter

Two-requester arbiter that shares the single I2C master pin path between two transaction engines. It owns the select line of the 2:1 SDA/SCL steering muxes: SEL=1 routes requester 0's A input, SEL=0 routes requester 1's B input. It grants ownership round-robin, holds the grant until the owner releases, and enforces a bus-free guard time between owners. A hold timeout stops a hung owner from locking the bus.

## Interface
- IDLE_CYCLES, 8: consecutive cycles with SCL_IN=SDA_IN=1 required before any grant (≥1).
- TIMEOUT, 1024: maximum cycles a grant may be held (≥2).
- CLK  input  1  system clock, all state on rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- REQ0  input  1  requester 0 wants the bus; held high for the whole ownership.
- REQ1  input  1  requester 1, same rules.
- SCL_IN  input  1  sensed SCL line, already synchronised.
- SDA_IN  input  1  sensed SDA line, already synchronised.
- GNT0  output  1  requester 0 owns the bus.
- GNT1  output  1  requester 1 owns the bus.
- SEL  output  1  drives S of the SDA/SCL muxes. 1 selects requester 0, 0 selects requester 1.
- BUSY  output  1  GNT0 | GNT1.
- TIMEOUT_ERR  output  1  one-cycle pulse on forced release.

## Operation
- One clock domain; reset is asynchronous and active-low.
- All outputs are registered.
- Reset values: GNT0=0, GNT1=0, BUSY=0, TIMEOUT_ERR=0, SEL=1. Also last=1, lock0=lock1=0, idle_cnt=0, hold_cnt=0, state=IDLE.
- idle_cnt:
  - Increments when SCL_IN&SDA_IN=1 and saturates at IDLE_CYCLES.
  - Cleared to 0 on any cycle with either line low.
  - Also cleared on the release edge, so the full guard time applies between owners.
  - bus_free = (idle_cnt == IDLE_CYCLES).
- Counter width: idle_cnt is ceil(log2(IDLE_CYCLES+1)) bits; hold_cnt is ceil(log2(TIMEOUT)) bits.
- States: IDLE, OWN0, OWN1.
- IDLE, with bus_free:
  - eligible0 = REQ0 & ~lock0; eligible1 = REQ1 & ~lock1.
  - Only one eligible: grant it.
  - Both eligible: grant the requester ≠ last.
  - On grant: move to OWNx, set GNTx, set SEL (1 for 0, 0 for 1), clear hold_cnt.
- IDLE, bus not free: no grant; requests wait, nothing is dropped.
- OWNx, normal release: REQx=0 → IDLE; GNTx←0; last←x; idle_cnt←0.
- OWNx, timeout: REQx=1 and hold_cnt==TIMEOUT-1 → IDLE; GNTx←0; TIMEOUT_ERR←1 for one cycle; last←x; lockx←1; idle_cnt←0.
- OWNx, otherwise: hold_cnt increments.
- REQx low on the same cycle as the timeout is a normal release: no error, no lock.
- lockx clears on any cycle REQx=0. A timed-out requester must drop its request before it can be granted again.
- SEL changes only on a grant edge. It holds its last value while idle.
- Requests from the non-owner during OWNx are ignored until IDLE.
- GNT0 and GNT1 are never high together.
- RST_N low at any time, including mid-ownership, forces the reset values immediately.

## Timing
- Grant latency: REQx high with bus_free at edge k → GNTx and SEL valid after edge k (1 cycle).
- Release: REQx low sampled at edge r → GNTx low after edge r.
- Earliest next grant: after edge r+IDLE_CYCLES+1, and only if the bus stays high throughout.
- Timeout: GNTx is high for exactly TIMEOUT cycles. TIMEOUT_ERR is high in the cycle after GNTx falls.
- Bus activity during the guard time restarts the count. Grant waits for IDLE_CYCLES uninterrupted idle cycles.

## Test plan
1. Reset and first grant (IDLE_CYCLES=8):
   - Hold RST_N=0; check GNT0=GNT1=0, SEL=1, TIMEOUT_ERR=0.
   - Release reset with bus high and REQ1=1.
   - Required: GNT1=1 and SEL=0 after edge 9, not earlier.
2. Round-robin:
   - REQ0=REQ1=1 from reset → GNT0 first.
   - Drop REQ0 for 1 cycle → GNT0 falls.
   - GNT1 rises 9 edges later, even though REQ0 is high again.
   - Drop REQ1 → GNT0 granted next.
3. Guard restart:
   - After a release, pull SDA_IN low at guard cycle 5.
   - Required: no grant until 8 further consecutive idle cycles; no GNT glitch.
4. Timeout (TIMEOUT=16):
   - Hold REQ0=1 indefinitely.
   - Required: GNT0 high exactly 16 cycles, then TIMEOUT_ERR one-cycle pulse.
   - REQ1=1 is granted after the guard time.
   - REQ0 is not re-granted until it drops and re-asserts.
   - Repeat with REQ0 dropped on cycle 16: required no TIMEOUT_ERR.
5. Reset mid-ownership:
   - Assert RST_N=0 asynchronously, between edges, while GNT1=1.
   - Required: GNT1=0, SEL=1 and BUSY=0 before the next edge.
   - After reset: lock flags cleared, last=1.
6. Mutual exclusion:
   - 10,000 cycles of random REQ0/REQ1/SCL_IN/SDA_IN.
   - Assert every cycle: never GNT0&GNT1; SEL==1 whenever GNT0; SEL==0 whenever GNT1.
